// File: rtl/fpu_arbiter.sv
// fpu_arbiter: two-port round-robin front end that shares one fpu_core.
// It holds one operation at a time and returns the result to the port
// that issued it. If the core stays busy for TIMEOUT cycles, it returns
// an error completion instead.

package fpu_p;
   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2
   } Operation;
endpackage

module fpu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  fpu_p::Operation      req_op0,
   input  fpu_p::Operation      req_op1,
   input  logic [WIDTH-1:0]     req_a0,
   input  logic [WIDTH-1:0]     req_b0,
   input  logic [WIDTH-1:0]     req_a1,
   input  logic [WIDTH-1:0]     req_b1,
   output logic [1:0]           rsp_valid,
   input  logic [1:0]           rsp_ready,
   output logic [WIDTH-1:0]     rsp_data,
   output logic                 rsp_err,
   output logic                 fpu_start,
   output fpu_p::Operation      fpu_op,
   output logic [WIDTH-1:0]     fpu_a,
   output logic [WIDTH-1:0]     fpu_b,
   input  logic                 fpu_busy,
   input  logic [WIDTH-1:0]     fpu_result
);

   // The WAIT counter only needs to reach TIMEOUT-1. The cycle that sees
   // that value while the core is still busy is the last WAIT cycle.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             r_rr;
   logic             r_gnt;
   fpu_p::Operation  r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             w_gnt;
   logic             w_accept;
   logic             w_done;
   logic             w_tmo;

   // If only one port is valid, it wins. If both are valid, the rr pointer decides.
   assign w_gnt = (&req_valid) ? r_rr : req_valid[1];

   // State register. An asynchronous reset drops any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Next-state logic and all handshake/core outputs, decoded from the current state.
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_done    = 1'b0;
      w_tmo     = 1'b0;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      fpu_start = 1'b0;
      fpu_op    = fpu_p::ADD;
      fpu_a     = '0;
      fpu_b     = '0;
      case (r_state)
         S_IDLE: begin
            if (|req_valid) begin
               req_ready[w_gnt] = 1'b1;
               w_accept         = 1'b1;
               w_next           = S_ISSUE;
            end
         end
         S_ISSUE: begin
            fpu_start = 1'b1;
            fpu_op    = r_op;
            fpu_a     = r_a;
            fpu_b     = r_b;
            w_next    = S_WAIT;
         end
         S_WAIT: begin
            if (!fpu_busy) begin
               w_done = 1'b1;
               w_next = S_RESP;
            end else if (r_cnt == TO_LAST) begin
               w_tmo  = 1'b1;
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid[r_gnt] = 1'b1;
            if (rsp_ready[r_gnt]) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Capture the accepted request and advance rr. Count WAIT cycles. Capture the response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr     <= 1'b0;
         r_gnt    <= 1'b0;
         r_op     <= fpu_p::ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_gnt <= w_gnt;
            r_rr  <= ~w_gnt;
            if (w_gnt) begin
               r_op <= req_op1;
               r_a  <= req_a1;
               r_b  <= req_b1;
            end else begin
               r_op <= req_op0;
               r_a  <= req_a0;
               r_b  <= req_b0;
            end
         end
         if (r_state == S_WAIT) r_cnt <= r_cnt + CW'(1);
         else                   r_cnt <= '0;
         if (w_done) begin
            rsp_data <= fpu_result;
            rsp_err  <= 1'b0;
         end else if (w_tmo) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
         end
      end
   end

endmodule
